// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - FSM state types and round-robin helper shared by axi_rr_arbiter
package axi_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // Position after idx in a ring of n masters; the next search starts here.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational pick of the first requester at or after a rotating pointer
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    int pos;
    pos   = 0;
    valid = |req;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (req[pos]) idx = IDX_W'(pos);
    end
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// rtl/axi_rr_arbiter.sv - N-master to 1-slave AXI4-Lite round-robin arbiter; AXI_RR_ARB_STAT_EN adds grant counters
module axi_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_arvalid,
  output logic [N_MASTERS-1:0]          m_arready,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
  output logic [N_MASTERS-1:0]          m_rvalid,
  input  logic [N_MASTERS-1:0]          m_rready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [N_MASTERS-1:0]          m_rresp,
  input  logic [N_MASTERS-1:0]          m_awvalid,
  output logic [N_MASTERS-1:0]          m_awready,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_awaddr,
  input  logic [N_MASTERS-1:0]          m_wvalid,
  output logic [N_MASTERS-1:0]          m_wready,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wmask,
  output logic [N_MASTERS-1:0]          m_bvalid,
  input  logic [N_MASTERS-1:0]          m_bready,
  output logic [N_MASTERS-1:0]          m_bresp,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  output logic [ADDR_W-1:0]             s_araddr,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_rresp,
  output logic                          s_awvalid,
  input  logic                          s_awready,
  output logic [ADDR_W-1:0]             s_awaddr,
  output logic                          s_wvalid,
  input  logic                          s_wready,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_wmask,
  input  logic                          s_bvalid,
  output logic                          s_bready,
  input  logic                          s_bresp
`ifdef AXI_RR_ARB_STAT_EN
  ,
  output logic [N_MASTERS*32-1:0]       rd_grant_cnt,
  output logic [N_MASTERS*32-1:0]       wr_grant_cnt
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_MASTERS);

  rd_state_t        rd_state, rd_state_nxt;
  logic [IDX_W-1:0] r_gnt, r_ptr, r_pick_idx;
  logic             r_pick_valid;
  logic             ar_hs, r_hs;

  wr_state_t        wr_state, wr_state_nxt;
  logic [IDX_W-1:0] w_gnt, w_ptr, w_pick_idx;
  logic             w_pick_valid;
  logic             aw_done, w_done;
  logic             aw_hs, w_hs, b_hs;

  rr_pick #(.N(N_MASTERS), .IDX_W(IDX_W)) u_rd_pick (
    .req   (m_arvalid),
    .ptr   (r_ptr),
    .valid (r_pick_valid),
    .idx   (r_pick_idx)
  );

  rr_pick #(.N(N_MASTERS), .IDX_W(IDX_W)) u_wr_pick (
    .req   (m_awvalid | m_wvalid),
    .ptr   (w_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  // Slave readies are only routed out in their own phase, so these are phase-qualified.
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;

  assign m_rdata = s_rdata;

  // Read state, latched grant and rotating pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= R_IDLE;
      r_gnt    <= '0;
      r_ptr    <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (rd_state == R_IDLE && r_pick_valid) r_gnt <= r_pick_idx;
      if (r_hs) r_ptr <= IDX_W'(rr_next(int'(r_gnt), N_MASTERS));
    end
  end

  // Read next state: address phase, then data phase, then back to arbitration.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (r_pick_valid) rd_state_nxt = R_ADDR;
      R_ADDR:  if (ar_hs)        rd_state_nxt = R_DATA;
      R_DATA:  if (r_hs)         rd_state_nxt = R_IDLE;
      default:                   rd_state_nxt = R_IDLE;
    endcase
  end

  // Read outputs: only the granted master is connected, everyone else sees zeros.
  always_comb begin
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rresp   = '0;
    case (rd_state)
      R_ADDR: begin
        s_arvalid        = 1'b1;
        s_araddr         = m_araddr[int'(r_gnt)*ADDR_W +: ADDR_W];
        m_arready[r_gnt] = s_arready;
      end
      R_DATA: begin
        m_rvalid[r_gnt] = s_rvalid;
        m_rresp[r_gnt]  = s_rresp;
        s_rready        = m_rready[r_gnt];
      end
      default: ;
    endcase
  end

  // Write state, latched grant, per-channel done flags and rotating pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      w_gnt    <= '0;
      w_ptr    <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      if (wr_state == W_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (w_pick_valid) w_gnt <= w_pick_idx;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (b_hs) w_ptr <= IDX_W'(rr_next(int'(w_gnt), N_MASTERS));
    end
  end

  // Write next state: AW and W may finish in either order or together before B.
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (w_pick_valid) wr_state_nxt = W_REQ;
      W_REQ:   if ((aw_done | aw_hs) && (w_done | w_hs)) wr_state_nxt = W_RESP;
      W_RESP:  if (b_hs) wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Write outputs: slave valids depend on state and done flags only, so they never retract.
  always_comb begin
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wmask   = '0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    case (wr_state)
      W_REQ: begin
        s_awvalid        = ~aw_done;
        s_wvalid         = ~w_done;
        s_awaddr         = m_awaddr[int'(w_gnt)*ADDR_W +: ADDR_W];
        s_wdata          = m_wdata[int'(w_gnt)*DATA_W +: DATA_W];
        s_wmask          = m_wmask[int'(w_gnt)*STRB_W +: STRB_W];
        m_awready[w_gnt] = s_awready & ~aw_done;
        m_wready[w_gnt]  = s_wready & ~w_done;
      end
      W_RESP: begin
        m_bvalid[w_gnt] = s_bvalid;
        m_bresp[w_gnt]  = s_bresp;
        s_bready        = m_bready[w_gnt];
      end
      default: ;
    endcase
  end

`ifdef AXI_RR_ARB_STAT_EN
  // Per-master completion counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_grant_cnt <= '0;
      wr_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (r_hs && int'(r_gnt) == i && rd_grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)
          rd_grant_cnt[i*32 +: 32] <= rd_grant_cnt[i*32 +: 32] + 32'd1;
        if (b_hs && int'(w_gnt) == i && wr_grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)
          wr_grant_cnt[i*32 +: 32] <= wr_grant_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule
